ct_lsu_dcache_tag_arb_inv: RTL

- Upstream driver of the L1 D-cache load-side tag SRAM wrapper (2-way, 27 bits per way, packed into one 54-bit word).
- Arbitrates three requesters for the single-port tag array: the invalidate-all sweep engine, refill tag writes and load-pipe tag reads.
- Generates the active-low SRAM controls, index, write data and gated-clock enable.
- Registers a read-data-valid strobe aligned with the SRAM output.

---
 rtl/ct_lsu_dcache_tag_arb_inv.sv | 115 +++++++++++
 1 files changed

// File: rtl/ct_lsu_dcache_tag_arb_inv.sv
// L1 D-cache load-side tag array arbiter: invalidate-all sweep > refill write > load read.
// LSU_DCACHE_TAG_INIT_ON_RESET_EN: when defined, a sweep runs automatically after reset.
module ct_lsu_dcache_tag_arb_inv #(
  parameter int unsigned IDX_W = 9,
  parameter int unsigned TAG_W = 26
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  input  logic                     cp0_lsu_dcache_inv_req,
  output logic                     lsu_cp0_dcache_inv_done,
  output logic                     inv_busy,
  input  logic                     wr_req,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic                     wr_way,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic                     wr_vld,
  output logic                     wr_grnt,
  input  logic                     ld_req,
  input  logic [IDX_W-1:0]         ld_idx,
  output logic                     ld_grnt,
  output logic                     ld_dout_vld,
  output logic                     tag_gateclk_en,
  output logic                     tag_sel_b,
  output logic                     tag_gwen_b,
  output logic [1:0]               tag_wen_b,
  output logic [IDX_W-1:0]         tag_idx,
  output logic [2*(TAG_W+1)-1:0]   tag_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INV  = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef LSU_DCACHE_TAG_INIT_ON_RESET_EN
  localparam state_e RST_ST = INV;
`else
  localparam state_e RST_ST = IDLE;
`endif

  state_e             state_q;
  logic [IDX_W-1:0]   inv_cnt_q;
  logic               ld_dout_vld_q;

  logic               st_idle;
  logic               inv_act;
  logic               wr_go;
  logic               ld_go;

  // Everything below is qualified by cpurst_b so the array idles for the whole reset window.
  always_comb begin
    st_idle = cpurst_b && (state_q == IDLE);
    inv_act = cpurst_b && (state_q == INV);
    wr_go   = st_idle && !cp0_lsu_dcache_inv_req && wr_req;
    ld_go   = st_idle && !cp0_lsu_dcache_inv_req && !wr_req && ld_req;
  end

  always_comb begin
    tag_sel_b  = 1'b1;
    tag_gwen_b = 1'b1;
    tag_wen_b  = 2'b11;
    tag_idx    = '0;
    tag_din    = '0;
    if (inv_act) begin
      tag_sel_b  = 1'b0;
      tag_gwen_b = 1'b0;
      tag_wen_b  = 2'b00;
      tag_idx    = inv_cnt_q;
    end else if (wr_go) begin
      tag_sel_b  = 1'b0;
      tag_gwen_b = 1'b0;
      tag_wen_b  = wr_way ? 2'b01 : 2'b10;
      tag_idx    = wr_idx;
      tag_din    = {2{wr_vld, wr_tag}};
    end else if (ld_go) begin
      tag_sel_b  = 1'b0;
      tag_idx    = ld_idx;
    end
  end

  assign tag_gateclk_en          = ~tag_sel_b;
  assign wr_grnt                 = wr_go;
  assign ld_grnt                 = ld_go;
  assign inv_busy                = inv_act;
  assign lsu_cp0_dcache_inv_done = cpurst_b && (state_q == DONE);
  assign ld_dout_vld             = ld_dout_vld_q;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q       <= RST_ST;
      inv_cnt_q     <= '0;
      ld_dout_vld_q <= 1'b0;
    end else begin
      ld_dout_vld_q <= ld_go;
      case (state_q)
        IDLE: begin
          if (cp0_lsu_dcache_inv_req) begin
            state_q   <= INV;
            inv_cnt_q <= '0;
          end
        end
        INV: begin
          inv_cnt_q <= inv_cnt_q + 1'b1;
          if (inv_cnt_q == '1) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
